// File: rtl/tx_serial_fila.sv
// Buffered 8N1 serial transmitter: a small byte FIFO feeding an LSB-first UART framer on TX.
// Define SERIAL_PARIDADE_EN to insert an even-parity bit (8E1 framing).
module tx_serial_fila #(
    parameter int CICLOS_POR_BIT    = 434,
    parameter int PROFUNDIDADE_FILA = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] dados,
    input  logic       escreve,
    output logic       TX,
    output logic       ocupado,
    output logic       fila_cheia,
    output logic       fila_vazia,
    output logic       fim_transmissao,
    output logic       erro_overflow
);

    localparam int PW = $clog2(PROFUNDIDADE_FILA);
    localparam int CW = $clog2(PROFUNDIDADE_FILA) + 1;
    localparam int BW = $clog2(CICLOS_POR_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CICLOS_POR_BIT - 1);
    localparam logic [CW-1:0] CHEIA    = CW'(PROFUNDIDADE_FILA);

`ifdef SERIAL_PARIDADE_EN
    typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} estado_t;
`else
    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} estado_t;
`endif

    logic [7:0]    mem [PROFUNDIDADE_FILA];
    logic [PW-1:0] ptr_esc;
    logic [PW-1:0] ptr_lei;
    logic [CW-1:0] contagem;
    logic [CW-1:0] contagem_n;

    estado_t       estado;
    estado_t       estado_n;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    byte_tx;
    logic [7:0]    byte_tx_n;
    logic          tx_n;
    logic          fim_n;
    logic          pop;
    logic          aceita;
    logic          fim_bit;

    // Full is judged on the registered flag, so a pop on the same edge cannot rescue a write.
    assign aceita  = escreve && !fila_cheia;
    assign fim_bit = (baud == BAUD_MAX);

    always_comb begin
        contagem_n = contagem;
        case ({aceita, pop})
            2'b10:   contagem_n = contagem + CW'(1);
            2'b01:   contagem_n = contagem - CW'(1);
            default: contagem_n = contagem;
        endcase
    end

    always_comb begin
        estado_n  = estado;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        byte_tx_n = byte_tx;
        tx_n      = TX;
        pop       = 1'b0;
        case (estado)
            OCIOSO: begin
                tx_n      = 1'b1;
                baud_n    = '0;
                bit_idx_n = '0;
                if (!fila_vazia) begin
                    pop       = 1'b1;
                    byte_tx_n = mem[ptr_lei];
                    tx_n      = 1'b0;
                    estado_n  = INICIO;
                end
            end
            INICIO: begin
                if (fim_bit) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    tx_n      = byte_tx[0];
                    estado_n  = DADOS;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            DADOS: begin
                if (fim_bit) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_PARIDADE_EN
                        tx_n     = ^byte_tx;
                        estado_n = PARIDADE;
`else
                        tx_n     = 1'b1;
                        estado_n = PARADA;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = byte_tx[bit_idx + 3'd1];
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
`ifdef SERIAL_PARIDADE_EN
            PARIDADE: begin
                if (fim_bit) begin
                    baud_n   = '0;
                    tx_n     = 1'b1;
                    estado_n = PARADA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
`endif
            PARADA: begin
                if (fim_bit) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fila_vazia) begin
                        pop       = 1'b1;
                        byte_tx_n = mem[ptr_lei];
                        tx_n      = 1'b0;
                        estado_n  = INICIO;
                    end else begin
                        tx_n     = 1'b1;
                        estado_n = OCIOSO;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: begin
                tx_n     = 1'b1;
                baud_n   = '0;
                estado_n = OCIOSO;
            end
        endcase
        fim_n = (estado_n == PARADA) && (baud_n == BAUD_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= OCIOSO;
            baud            <= '0;
            bit_idx         <= '0;
            TX              <= 1'b1;
            ocupado         <= 1'b0;
            fim_transmissao <= 1'b0;
            ptr_esc         <= '0;
            ptr_lei         <= '0;
            contagem        <= '0;
            fila_cheia      <= 1'b0;
            fila_vazia      <= 1'b1;
            erro_overflow   <= 1'b0;
        end else begin
            estado          <= estado_n;
            baud            <= baud_n;
            bit_idx         <= bit_idx_n;
            TX              <= tx_n;
            ocupado         <= (estado_n != OCIOSO);
            fim_transmissao <= fim_n;
            contagem        <= contagem_n;
            fila_cheia      <= (contagem_n == CHEIA);
            fila_vazia      <= (contagem_n == '0);
            if (aceita) begin
                ptr_esc <= ptr_esc + PW'(1);
            end
            if (pop) begin
                ptr_lei <= ptr_lei + PW'(1);
            end
            if (escreve && fila_cheia) begin
                erro_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; pointers and count define which entries are valid.
    always_ff @(posedge clock) begin
        byte_tx <= byte_tx_n;
        if (aceita) begin
            mem[ptr_esc] <= dados;
        end
    end

endmodule

// File: tb/tb_tx_serial_fila.sv
// Bench for tx_serial_fila: directed scenarios plus random bytes, every cycle compared to a frame-level model.
module tb_tx_serial_fila;

    localparam int C     = 434;
    localparam int DEPTH = 4;
`ifdef SERIAL_PARIDADE_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       escreve = 1'b0;
    logic [7:0] dados = 8'h00;
    logic       TX;
    logic       ocupado;
    logic       fila_cheia;
    logic       fila_vazia;
    logic       fim_transmissao;
    logic       erro_overflow;

    always #5 clock = ~clock;

    tx_serial_fila #(.CICLOS_POR_BIT(C), .PROFUNDIDADE_FILA(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .dados(dados),
        .escreve(escreve),
        .TX(TX),
        .ocupado(ocupado),
        .fila_cheia(fila_cheia),
        .fila_vazia(fila_vazia),
        .fim_transmissao(fim_transmissao),
        .erro_overflow(erro_overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Frame-level model: pending byte queue, plus the byte on the line and cycles since its start edge.
    logic [7:0] q[$];
    logic       m_ativo = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf = 1'b0;

    function automatic logic bit_esperado(input logic [7:0] b, input int t);
        int idx;
        idx = t / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NB == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic wr, input logic [7:0] d, input logic rst_i);
        int pre;
        if (rst_i) begin
            q.delete();
            m_ativo = 1'b0;
            m_t     = 0;
            m_ovf   = 1'b0;
            return;
        end
        pre = q.size();
        if (m_ativo) begin
            m_t++;
            if (m_t == FRAME) begin
                if (pre > 0) begin
                    m_byte = q.pop_front();
                    m_t    = 0;
                end else begin
                    m_ativo = 1'b0;
                end
            end
        end else if (pre > 0) begin
            m_byte  = q.pop_front();
            m_ativo = 1'b1;
            m_t     = 0;
        end
        if (wr) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else q.push_back(d);
        end
    endtask

    task automatic tick(input logic wr, input logic [7:0] d, input logic rst_i);
        logic [5:0] got;
        logic [5:0] exp;
        escreve = wr;
        dados   = d;
        reset   = rst_i;
        @(posedge clock);
        cyc++;
        model_edge(wr, d, rst_i);
        #1;
        got = {TX, ocupado, fila_cheia, fila_vazia, fim_transmissao, erro_overflow};
        exp = {(m_ativo ? bit_esperado(m_byte, m_t) : 1'b1), m_ativo,
               (q.size() == DEPTH), (q.size() == 0),
               (m_ativo && m_t == FRAME - 1), m_ovf};
        check("model_outputs", 32'(got), 32'(exp));
    endtask

    initial begin
        int s, f, o, kw, fims, tr, f1, f2;
        logic prev;
        logic [7:0] rx;
        logic [7:0] b;

        repeat (10) tick(1'b0, 8'h00, 1'b1);
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_vazia", 32'(fila_vazia), 32'd1);
        check("reset_ocupado", 32'(ocupado), 32'd0);
        check("reset_overflow", 32'(erro_overflow), 32'd0);

        tr = 0;
        prev = TX;
        repeat (1000) begin
            tick(1'b0, 8'h00, 1'b0);
            if (TX !== prev) tr++;
            prev = TX;
        end
        check("idle_tx_transitions", 32'(tr), 32'd0);

        // Single byte 0x1D
        tick(1'b1, 8'h1D, 1'b0);
        kw = cyc;
        check("write_vazia_fall", 32'(fila_vazia), 32'd0);
        s = -1; f = -1; o = -1; fims = 0; rx = 8'h00;
        for (int i = 0; i < FRAME + 20; i++) begin
            int off;
            tick(1'b0, 8'h00, 1'b0);
            if (i == 0) check("pop_vazia_rise", 32'(fila_vazia), 32'd1);
            if (s < 0 && TX === 1'b0) s = cyc;
            if (fim_transmissao === 1'b1) begin
                fims++;
                f = cyc;
            end
            if (s >= 0 && o < 0 && ocupado === 1'b0) o = cyc;
            if (s >= 0) begin
                off = cyc - s;
                if (off >= C && off < 9 * C && (off % C) == C / 2) rx[off / C - 1] = TX;
`ifdef SERIAL_PARIDADE_EN
                if (off == 9 * C + C / 2) check("parity_1d", 32'(TX), 32'd0);
`endif
            end
        end
        check("start_latency", 32'(s - kw), 32'd1);
        check("rx_byte_1d", 32'(rx), 32'h1D);
        check("fim_offset", 32'(f - s), 32'(FRAME - 1));
        check("ocupado_fall", 32'(o - s), 32'(FRAME));
        check("fim_count_1d", 32'(fims), 32'd1);

        // Six consecutive writes into a four-deep FIFO
        s = -1;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            if (s < 0 && ocupado === 1'b1) s = cyc;
            if (i == 5) check("burst_cheia", 32'(fila_cheia), 32'd1);
            if (i == 6) check("burst_overflow", 32'(erro_overflow), 32'd1);
        end
        o = -1; fims = 0;
        for (int i = 0; i < 5 * FRAME + 100; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (fim_transmissao === 1'b1) fims++;
            if (ocupado === 1'b0) begin
                o = cyc;
                break;
            end
        end
        check("burst_total_cycles", 32'(o - s), 32'(5 * FRAME));
        check("burst_fim_count", 32'(fims), 32'd5);

        // Reset during data bit 3 of 0x1E
        tick(1'b1, 8'h1E, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            if (m_ativo && m_t == 4 * C + C / 2) break;
            tick(1'b0, 8'h00, 1'b0);
        end
        check("abort_busy_before", 32'(ocupado), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        check("abort_tx", 32'(TX), 32'd1);
        check("abort_vazia", 32'(fila_vazia), 32'd1);
        check("abort_overflow_clear", 32'(erro_overflow), 32'd0);
        tr = 0;
        prev = TX;
        repeat (1500) begin
            tick(1'b0, 8'h00, 1'b0);
            if (TX !== prev) tr++;
            prev = TX;
        end
        check("abort_tx_transitions", 32'(tr), 32'd0);

        // 0x1D queued while 0x1E is mid-frame
        tick(1'b1, 8'h1E, 1'b0);
        repeat (3 * C) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h1D, 1'b0);
        f1 = -1; f2 = -1; fims = 0;
        for (int i = 0; i < 2 * FRAME + 50; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (fims == 1 && f1 == cyc - 1) begin
                check("b2b_start_tx", 32'(TX), 32'd0);
                check("b2b_start_ocupado", 32'(ocupado), 32'd1);
            end
            if (fim_transmissao === 1'b1) begin
                fims++;
                if (fims == 1) f1 = cyc;
                else f2 = cyc;
            end
            if (ocupado === 1'b0) break;
        end
        check("b2b_fim_count", 32'(fims), 32'd2);
        check("b2b_fim_spacing", 32'(f2 - f1), 32'(FRAME));

        // Random bytes at random times, including writes while busy
        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 40)) tick(1'b0, 8'h00, 1'b0);
            tick(1'b1, b, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, FRAME / 2)) tick(1'b0, 8'h00, 1'b0);
                tick(1'b1, 8'($urandom), 1'b0);
            end
            repeat ($urandom_range(C, FRAME)) tick(1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 6 * FRAME; i++) begin
            if (!m_ativo && q.size() == 0) break;
            tick(1'b0, 8'h00, 1'b0);
        end
        tick(1'b0, 8'h00, 1'b0);
        check("drain_ocupado", 32'(ocupado), 32'd0);
        check("drain_vazia", 32'(fila_vazia), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
